// File: rtl/blake_core_arbiter.sv
// blake_core_arbiter: shares one blake_64 compression core among NUM_REQ
// message requesters. Round-robin grant, registered 640-bit block to the core,
// one-cycle ena pulse, wait for rdy, then hold the 512-bit digest plus owner id
// until the consumer accepts it.
// Optional build macro: BLAKE_ARB_PRIO0_EN (requester 0 gets strict priority).
module blake_core_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*640-1:0] req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [511:0]           rsp_data,
  output logic                   core_ena,
  output logic [639:0]           core_din,
  input  logic                   core_rdy,
  input  logic [511:0]           core_dout,
  output logic                   busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [ID_W-1:0] cur_id;
  logic [ID_W-1:0] grant_id;
  logic            grant_any;

  // Grant search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int unsigned     pos;
    logic [ID_W-1:0] pidx;
    grant_id  = '0;
    grant_any = |req_valid;
    pos       = 0;
    pidx      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = 32'(rr_ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      pidx = ID_W'(pos);
      // scan from the highest offset down so the nearest valid one wins
      if (req_valid[ID_W'(32'(rr_ptr) + (NUM_REQ - 1 - k) >= NUM_REQ ?
                          32'(rr_ptr) + (NUM_REQ - 1 - k) - NUM_REQ :
                          32'(rr_ptr) + (NUM_REQ - 1 - k))])
        grant_id = ID_W'(32'(rr_ptr) + (NUM_REQ - 1 - k) >= NUM_REQ ?
                         32'(rr_ptr) + (NUM_REQ - 1 - k) - NUM_REQ :
                         32'(rr_ptr) + (NUM_REQ - 1 - k));
    end
`ifdef BLAKE_ARB_PRIO0_EN
    if (req_valid[0]) grant_id = '0;
`endif
  end

  // Next-state, grant strobe, core start pulse and pointer advance.
  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    req_ready  = '0;
    core_ena   = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        // rstb gating keeps the accept strobe low while the block is held in reset
        if (grant_any && rstb) begin
          req_ready[grant_id] = 1'b1;
          state_nxt           = S_LAUNCH;
          rr_ptr_nxt          = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
`ifdef BLAKE_ARB_PRIO0_EN
          if (req_valid[0]) rr_ptr_nxt = rr_ptr;
`endif
        end
      end
      S_LAUNCH: begin
        core_ena  = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (core_rdy) state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Datapath: block capture at grant, digest capture on core_rdy in WAIT.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rr_ptr    <= '0;
      cur_id    <= '0;
      core_din  <= '0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_valid <= 1'b0;
    end else begin
      rr_ptr <= rr_ptr_nxt;
      if (state == S_IDLE && grant_any) begin
        core_din <= req_data[int'(grant_id)*640 +: 640];
        cur_id   <= grant_id;
      end
      if (state == S_WAIT && core_rdy) begin
        rsp_data  <= core_dout;
        rsp_id    <= cur_id;
        rsp_valid <= 1'b1;
      end else if (state == S_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_blake_core_arbiter.sv
// Self-checking bench for blake_core_arbiter: reset values, a table of grant
// vectors, hand-written corner sequences and a randomized run against a
// transaction-level reference model. Honors BLAKE_ARB_PRIO0_EN.
module tb_blake_core_arbiter;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rstb;
  logic [N-1:0]     req_valid;
  logic [N*640-1:0] req_data;
  logic [N-1:0]     req_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic [511:0]     rsp_data;
  logic             core_ena;
  logic [639:0]     core_din;
  logic             core_rdy;
  logic [511:0]     core_dout;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic core_auto = 1'b0;
  logic core_rand = 1'b0;
  int   core_lat  = 8;
  int   cd        = 0;
  logic [639:0] blk [N];

  blake_core_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk(clk), .rstb(rstb), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .core_ena(core_ena),
    .core_din(core_din), .core_rdy(core_rdy), .core_dout(core_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] digest(input logic [639:0] d);
    return d[511:0] ^ {4{d[639:512]}};
  endfunction

  function automatic logic [639:0] rand_block();
    logic [639:0] b;
    for (int w = 0; w < 20; w++) b[w*32 +: 32] = $urandom();
    return b;
  endfunction

  // Reference grant rule: first valid at or after ptr (mod N); optional prio 0.
  function automatic int model_grant(input logic [N-1:0] v, input int ptr);
`ifdef BLAKE_ARB_PRIO0_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic int model_next_ptr(input int g, input int ptr);
`ifdef BLAKE_ARB_PRIO0_EN
    if (g == 0) return ptr;
`endif
    return (g + 1) % N;
  endfunction

  task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual=timeout required=event", nm);
  endtask

  task automatic set_blk(input int i, input logic [639:0] b);
    blk[i] = b;
    req_data[i*640 +: 640] = b;
  endtask

  task automatic wait_rsp(input int bound);
    int t;
    t = 0;
    while (!rsp_valid && t < bound) begin
      @(negedge clk); #1;
      t++;
    end
    if (!rsp_valid) timeout_fail("rsp_valid wait");
  endtask

  task automatic wait_grant(input int bound);
    int t;
    t = 0;
    #1;
    while (req_ready == '0 && t < bound) begin
      @(negedge clk); #1;
      t++;
    end
    if (req_ready == '0) timeout_fail("grant wait");
  endtask

  task automatic do_reset();
    @(negedge clk);
    core_auto = 1'b0;
    core_rand = 1'b0;
    core_rdy  = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    rstb      = 1'b0;
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    #1;
  endtask

  // Core model: answers each ena with one rdy pulse after a latency.
  initial begin
    core_rdy  = 1'b0;
    core_dout = '0;
    forever begin
      @(negedge clk);
      if (!rstb) cd = 0;
      else if (core_auto) begin
        core_rdy = 1'b0;
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            core_rdy  = 1'b1;
            core_dout = digest(core_din);
          end
        end
        if (core_ena) cd = core_rand ? int'($urandom_range(6, 1)) : core_lat;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=no finish required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [3:0] valid;
    logic [3:0] ready;
    logic [1:0] id;
  } vec_t;

  initial begin
    vec_t tbl [8];
    int   fair_exp [6];
    logic [511:0] d;
    logic [3:0]   e;
    logic [639:0] exp_blk;
    logic [1:0]   exp_id;
    logic [3:0]   taken;
    int g, phase, mptr, n_jobs;

`ifdef BLAKE_ARB_PRIO0_EN
    tbl[0] = '{4'b0100, 4'b0100, 2'd2};
    tbl[1] = '{4'b1111, 4'b0001, 2'd0};
    tbl[2] = '{4'b0110, 4'b0010, 2'd1};
    tbl[3] = '{4'b0011, 4'b0001, 2'd0};
    tbl[4] = '{4'b1001, 4'b0001, 2'd0};
    tbl[5] = '{4'b1110, 4'b0100, 2'd2};
    tbl[6] = '{4'b0100, 4'b0100, 2'd2};
    tbl[7] = '{4'b0001, 4'b0001, 2'd0};
    fair_exp = '{0, 0, 0, 1, 2, 3};
`else
    tbl[0] = '{4'b0100, 4'b0100, 2'd2};
    tbl[1] = '{4'b1111, 4'b1000, 2'd3};
    tbl[2] = '{4'b0110, 4'b0010, 2'd1};
    tbl[3] = '{4'b0011, 4'b0001, 2'd0};
    tbl[4] = '{4'b1001, 4'b1000, 2'd3};
    tbl[5] = '{4'b1110, 4'b0010, 2'd1};
    tbl[6] = '{4'b0100, 4'b0100, 2'd2};
    tbl[7] = '{4'b0001, 4'b0001, 2'd0};
    fair_exp = '{0, 1, 2, 3, 0, 1};
`endif

    rstb = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) set_blk(i, rand_block());

    // Reset values
    do_reset();
    chk("rst req_ready", req_ready, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_id", rsp_id, 0);
    chk("rst rsp_data", rsp_data, 0);
    chk("rst core_ena", core_ena, 0);
    chk("rst core_din", core_din, 0);
    chk("rst busy", busy, 0);

    // Table of grant vectors, one full job each, from rr_ptr=0
    core_auto = 1'b1;
    core_lat  = 8;
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < N; i++) set_blk(i, rand_block());
      req_valid = tbl[v].valid;
      rsp_ready = 1'b1;
      #1;
      chk("tbl req_ready", req_ready, tbl[v].ready);
      @(negedge clk); #1;
      req_valid = '0;
      chk("tbl core_ena", core_ena, 1);
      chk("tbl core_din", core_din, blk[tbl[v].id]);
      wait_rsp(20);
      chk("tbl rsp_id", rsp_id, tbl[v].id);
      chk("tbl rsp_data", rsp_data, digest(blk[tbl[v].id]));
      @(negedge clk); #1;
      chk("tbl rsp_clear", rsp_valid, 0);
    end

    // Fairness: all requesters held valid
    do_reset();
    core_auto = 1'b1;
    core_lat  = 8;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int j = 0; j < 6; j++) begin
`ifdef BLAKE_ARB_PRIO0_EN
      if (j == 3) req_valid[0] = 1'b0;
`endif
      wait_grant(30);
      g = -1;
      for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
      chk("fair grant", 640'(g), 640'(fair_exp[j]));
      d = (g >= 0) ? digest(blk[g]) : '0;
      @(negedge clk); #1;
      if (g >= 0) set_blk(g, rand_block());
      wait_rsp(20);
      chk("fair rsp_id", rsp_id, 640'(fair_exp[j]));
      chk("fair rsp_data", rsp_data, d);
      @(negedge clk);
    end

    // Backpressure: digest held 20 cycles, no new grant or core start
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    wait_grant(10);
    chk("bp grant", req_ready, 4'b0010);
    d = digest(blk[1]);
    @(negedge clk); #1;
    set_blk(1, rand_block());
    req_valid = 4'b1111;
    wait_rsp(20);
    for (int c = 0; c < 20; c++) begin
      chk("bp rsp_valid", rsp_valid, 1);
      chk("bp rsp_id", rsp_id, 1);
      chk("bp rsp_data", rsp_data, d);
      chk("bp req_ready", req_ready, 0);
      chk("bp core_ena", core_ena, 0);
      @(negedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    chk("bp released", rsp_valid, 0);
`ifdef BLAKE_ARB_PRIO0_EN
    chk("bp next grant", req_ready, 4'b0001);
`else
    chk("bp next grant", req_ready, 4'b0100);
`endif
    @(negedge clk); #1;
    req_valid = '0;
    wait_rsp(20);
    @(negedge clk); #1;

    // Spurious core_rdy in IDLE and LAUNCH
    core_auto = 1'b0;
    core_dout = rand_block()[511:0];
    core_rdy  = 1'b1;
    @(negedge clk); #1;
    core_rdy = 1'b0;
    chk("spur idle rsp_valid", rsp_valid, 0);
    chk("spur idle busy", busy, 0);
    set_blk(3, rand_block());
    req_valid = 4'b1000;
    #1;
    chk("spur grant", req_ready, 4'b1000);
    @(negedge clk); #1;
    req_valid = '0;
    chk("spur launch ena", core_ena, 1);
    core_dout = rand_block()[511:0];
    core_rdy  = 1'b1;
    @(negedge clk); #1;
    core_rdy = 1'b0;
    chk("spur wait ena", core_ena, 0);
    chk("spur wait busy", busy, 1);
    for (int c = 0; c < 3; c++) begin
      chk("spur launch rsp_valid", rsp_valid, 0);
      @(negedge clk); #1;
    end
    core_dout = digest(blk[3]);
    core_rdy  = 1'b1;
    @(negedge clk); #1;
    core_rdy = 1'b0;
    chk("spur done rsp_valid", rsp_valid, 1);
    chk("spur done rsp_id", rsp_id, 3);
    chk("spur done rsp_data", rsp_data, digest(blk[3]));
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    chk("spur done clear", rsp_valid, 0);

    // Reset in WAIT (rr_ptr is 3 after granting requester 2)
    set_blk(2, rand_block());
    req_valid = 4'b0100;
    #1;
    chk("rstw grant", req_ready, 4'b0100);
    @(negedge clk); #1;
    req_valid = '0;
    @(negedge clk); #1;
    chk("rstw busy before", busy, 1);
    req_valid = 4'b1111;
    rstb = 1'b0;
    #1;
    chk("rstw busy", busy, 0);
    chk("rstw core_ena", core_ena, 0);
    chk("rstw rsp_valid", rsp_valid, 0);
    chk("rstw rsp_id", rsp_id, 0);
    chk("rstw rsp_data", rsp_data, 0);
    chk("rstw core_din", core_din, 0);
    chk("rstw req_ready", req_ready, 0);
    @(negedge clk);
    @(negedge clk); #1;
    rstb = 1'b1;
    req_valid = 4'b1001;
    #1;
    chk("rstw ptr0 grant", req_ready, 4'b0001);
    core_auto = 1'b1;
    @(negedge clk); #1;
    req_valid = '0;
    chk("rstw core_ena", core_ena, 1);
    wait_rsp(20);
    chk("rstw rsp_id", rsp_id, 0);
    chk("rstw rsp_data", rsp_data, digest(blk[0]));
    @(negedge clk); #1;

    // Randomized run against the transaction-level model
    do_reset();
    core_auto = 1'b1;
    core_rand = 1'b1;
    phase  = 0;   // 0 idle, 1 start expected, 2 core busy, 3 digest held
    mptr   = 0;
    taken  = '0;
    n_jobs = 0;
    exp_blk = '0;
    exp_id  = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (taken[i]) begin
          taken[i] = 1'b0;
          req_valid[i] = 1'($urandom_range(1, 0));
          if (req_valid[i]) set_blk(i, rand_block());
        end else if (req_valid[i]) begin
          if ($urandom_range(9, 0) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(3, 0) == 0) begin
          set_blk(i, rand_block());
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = 1'($urandom_range(1, 0));
      #1;
      case (phase)
        0: begin
          chk("rnd idle busy", busy, 0);
          chk("rnd idle rsp_valid", rsp_valid, 0);
          g = model_grant(req_valid, mptr);
          if (g < 0) chk("rnd idle ready", req_ready, 0);
          else begin
            e = 4'b0001 << g;
            chk("rnd grant", req_ready, e);
            exp_id  = 2'(g);
            exp_blk = blk[g];
            mptr    = model_next_ptr(g, mptr);
            taken[g] = 1'b1;
            n_jobs++;
            phase = 1;
          end
        end
        1: begin
          chk("rnd core_ena", core_ena, 1);
          chk("rnd core_din", core_din, exp_blk);
          chk("rnd launch ready", req_ready, 0);
          chk("rnd launch busy", busy, 1);
          phase = 2;
        end
        2: begin
          chk("rnd wait ena", core_ena, 0);
          chk("rnd wait rsp_valid", rsp_valid, 0);
          chk("rnd wait ready", req_ready, 0);
          if (core_rdy) phase = 3;
        end
        default: begin
          chk("rnd rsp_valid", rsp_valid, 1);
          chk("rnd rsp_id", rsp_id, exp_id);
          chk("rnd rsp_data", rsp_data, digest(exp_blk));
          chk("rnd resp ena", core_ena, 0);
          chk("rnd resp ready", req_ready, 0);
          if (rsp_ready) phase = 0;
        end
      endcase
    end
    chk("rnd job count", 640'(n_jobs > 50), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
